psram_spi_master: RTL and testbench

FPGA-side SPI initiator for the on-board PSRAM: it issues single 32-bit word reads (0x03) and writes (0x02) with a 24-bit address over SPI mode 0. It drives the same PSRAM pins that the ESP32 otherwise reaches through the SPI pass-through path, so fabric logic can own PSRAM directly. An upstream arbiter selects between this block and the pass-through.

---
 rtl/psram_spi_master.sv | 151 +++++++++++++++
 tb/tb_psram_spi_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/psram_spi_master.sv
// SPI mode-0 initiator for single 32-bit PSRAM word reads (0x03) and writes (0x02).
// Every SPI pin, busy, ack and rdata comes straight from a flop.
module psram_spi_master #(
    parameter int unsigned HALF   = 1,
    parameter int unsigned CS_GAP = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        spi0_mosi,
    input  logic        spi0_miso,
    output logic        spi0_sclk,
    output logic        spi0_cs0,
    output logic        spi0_nwp,
    output logic        spi0_nhld
);

    localparam int unsigned MAXC = (HALF > CS_GAP) ? HALF : CS_GAP;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    bit_q, bit_d;
    logic [63:0]   sr_q, sr_d;
    logic [31:0]   rx_q, rx_d;
    logic          rd_q, rd_d;
    logic          sclk_d, cs_d, mosi_d, busy_d, ack_d;
    logic [31:0]   rdata_d;
    logic [7:0]    cmd;

    assign spi0_nwp  = 1'b1;
    assign spi0_nhld = 1'b1;

    always_comb begin
        cmd     = we ? 8'h02 : 8'h03;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        sclk_d  = spi0_sclk;
        cs_d    = spi0_cs0;
        mosi_d  = spi0_mosi;
        busy_d  = busy;
        ack_d   = 1'b0;
        rdata_d = rdata;
        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (req) begin
                    sr_d    = {cmd, addr, (we ? wdata : 32'h0)};
                    rd_d    = ~we;
                    cnt_d   = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = sr_d[63];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[30:0], spi0_miso};
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                // sclk itself tells which half of the bit-time we are in
                if (cnt_q != HALF_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (spi0_sclk) begin
                    sclk_d = 1'b0;
                    sr_d   = sr_q << 1;
                    mosi_d = sr_d[63];
                    cnt_d  = '0;
                end else if (bit_q == 6'd63) begin
                    state_d = GAP;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[30:0], spi0_miso};
                    bit_d  = bit_q + 6'd1;
                    cnt_d  = '0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    if (rd_q) rdata_d = rx_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sr_q      <= '0;
            rx_q      <= '0;
            rd_q      <= 1'b0;
            spi0_sclk <= 1'b0;
            spi0_cs0  <= 1'b1;
            spi0_mosi <= 1'b0;
            busy      <= 1'b0;
            ack       <= 1'b0;
            rdata     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sr_q      <= sr_d;
            rx_q      <= rx_d;
            rd_q      <= rd_d;
            spi0_sclk <= sclk_d;
            spi0_cs0  <= cs_d;
            spi0_mosi <= mosi_d;
            busy      <= busy_d;
            ack       <= ack_d;
            rdata     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_psram_spi_master.sv
// Bench for psram_spi_master: a PSRAM word-memory model on the pins plus cycle-exact
// expectations derived from the transaction timing rules.
module tb_psram_spi_master;

    localparam int H  = 1;
    localparam int G  = 2;
    localparam int A  = 1 + 129 * H + G;
    localparam int H3 = 3;
    localparam int G3 = 4;
    localparam int A3 = 1 + 129 * H3 + G3;

    logic        clk = 1'b0;
    logic        reset, req, we, miso;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic        busy, ack, mosi, sclk, cs0, nwp, nhld;
    logic [31:0] rdata;

    logic        req3, we3, miso3;
    logic [23:0] addr3;
    logic [31:0] wdata3;
    logic        busy3, ack3, mosi3, sclk3, cs3, nwp3, nhld3;
    logic [31:0] rdata3;

    psram_spi_master dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .spi0_mosi(mosi), .spi0_miso(miso),
        .spi0_sclk(sclk), .spi0_cs0(cs0), .spi0_nwp(nwp), .spi0_nhld(nhld)
    );

    psram_spi_master #(.HALF(H3), .CS_GAP(G3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
        .busy(busy3), .ack(ack3), .rdata(rdata3), .spi0_mosi(mosi3), .spi0_miso(miso3),
        .spi0_sclk(sclk3), .spi0_cs0(cs3), .spi0_nwp(nwp3), .spi0_nhld(nhld3)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rd_hold;
    logic [31:0] mem [int unsigned];

    typedef struct {
        bit          w;
        logic [23:0] a;
        logic [31:0] d;
        int          rst_at;
        int          p1;
        int          p2;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {~a[7:0], a};
    endfunction

    function automatic logic exp_sclk(input int k, input int h);
        if (k < h + 1 || k > 129 * h) return 1'b0;
        return ((k - (h + 1)) % (2 * h)) < h;
    endfunction

    // One transaction on the default instance with an attached PSRAM model.
    task automatic run_txn(input string tag, input bit w, input logic [23:0] a,
                           input logic [31:0] d, input int rst_at, input int p1, input int p2);
        logic [63:0] exp_bits, got_bits;
        logic [31:0] exp_rd, dev_word;
        logic [7:0]  dev_cmd;
        logic [23:0] dev_addr;
        logic        prev_sclk, prev_mosi, prev_cs, aborted;
        int nrise, acks, ack_at, cs_err, sclk_err, busy_err, stab_err, k_end;
        exp_bits = {(w ? 8'h02 : 8'h03), a, (w ? d : 32'h0)};
        exp_rd   = w ? rd_hold : mem_rd(a);
        got_bits = '0; dev_word = '0; dev_cmd = '0; dev_addr = '0;
        nrise = 0; acks = 0; ack_at = -1; cs_err = 0; sclk_err = 0; busy_err = 0; stab_err = 0;
        prev_sclk = 1'b0; prev_mosi = 1'b0; prev_cs = 1'b1;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        k_end = (rst_at >= 0) ? rst_at + 100 : A + 1;
        for (int k = 1; k <= k_end; k++) begin
            @(negedge clk);
            req   = (k == p1 || k == p2);
            reset = (k == rst_at);
            if (req) begin
                we = 1'($urandom); addr = 24'($urandom); wdata = $urandom;
            end
            aborted = (rst_at >= 0 && k > rst_at);
            if (cs0 !== (aborted ? 1'b1 : !(k >= 1 && k <= 129 * H))) cs_err++;
            if (sclk !== (aborted ? 1'b0 : exp_sclk(k, H))) sclk_err++;
            if (busy !== (!aborted && k >= 1 && k < A)) busy_err++;
            if (ack === 1'b1) begin
                acks++;
                ack_at = k;
                check({tag, " rdata@ack"}, rdata, exp_rd);
            end
            if (!cs0 && prev_cs) begin
                nrise = 0; dev_cmd = '0;
                miso = 1'($urandom);
            end
            if (!cs0 && sclk && !prev_sclk) begin
                if (mosi !== prev_mosi) stab_err++;
                got_bits = {got_bits[62:0], mosi};
                nrise++;
                if (nrise == 32) begin
                    dev_cmd  = got_bits[31:24];
                    dev_addr = got_bits[23:0];
                    if (dev_cmd == 8'h03) dev_word = mem_rd(dev_addr);
                end
                if (nrise >= 32 && nrise < 64 && dev_cmd == 8'h03) miso = dev_word[63 - nrise];
                else miso = 1'($urandom);
                if (nrise == 64 && dev_cmd == 8'h02) mem[int'(dev_addr)] = got_bits[31:0];
            end
            prev_sclk = sclk; prev_mosi = mosi; prev_cs = cs0;
        end
        req = 1'b0; reset = 1'b0;
        check({tag, " cs0 pattern errs"}, cs_err, 0);
        check({tag, " sclk pattern errs"}, sclk_err, 0);
        check({tag, " busy pattern errs"}, busy_err, 0);
        if (rst_at < 0) begin
            check({tag, " mosi stream"}, got_bits, exp_bits);
            check({tag, " rising edges"}, nrise, 64);
            check({tag, " mosi setup errs"}, stab_err, 0);
            check({tag, " ack count"}, acks, 1);
            check({tag, " ack cycle"}, ack_at, A);
            rd_hold = exp_rd;
        end else begin
            check({tag, " ack after abort"}, acks, 0);
            rd_hold = '0;
        end
    endtask

    initial begin
        int acks, first_ack, last_ack, cs_rise, cs_fall2, sclk_err, cs_err, rises, ack_at;
        logic prev_cs, prev_sclk;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; miso = 1'b0;
        req3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0; miso3 = 1'b1;
        rd_hold = '0;
        mem[int'(24'h000100)] = 32'hCAFEF00D;
        vecs[0] = '{1'b1, 24'h012345, 32'hDEADBEEF, -1, -1, -1};
        vecs[1] = '{1'b0, 24'h000100, 32'h0,        -1, -1, -1};
        vecs[2] = '{1'b1, 24'h000104, 32'h12345678, -1, -1, -1};
        vecs[3] = '{1'b0, 24'h000104, 32'h0,        -1,  5, 60};
        vecs[4] = '{1'b1, 24'h000300, 32'hA5A5A5A5, 40, -1, -1};
        vecs[5] = '{1'b0, 24'h000300, 32'h0,        -1, -1, -1};

        repeat (3) @(negedge clk);
        check("reset cs0", cs0, 1'b1);
        check("reset sclk", sclk, 1'b0);
        check("reset mosi", mosi, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset ack", ack, 1'b0);
        check("reset rdata", rdata, 32'h0);
        check("nwp/nhld", {nwp, nhld}, 2'b11);
        check("reset cs0 (HALF=3)", cs3, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d,
                    vecs[i].rst_at, vecs[i].p1, vecs[i].p2);
        check("rdata held after table", rdata, rd_hold);

        for (int i = 0; i < 20; i++)
            run_txn($sformatf("rand%0d", i), 1'($urandom),
                    24'h000200 + 24'($urandom_range(0, 7)) * 24'd4, $urandom, -1, -1, -1);

        // Back-to-back: req held high across the ack cycle.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 24'hFFFF00; wdata = $urandom;
        acks = 0; first_ack = -1; last_ack = -1; cs_rise = -1; cs_fall2 = -1; prev_cs = 1'b1;
        for (int k = 1; k <= 2 * A + 2; k++) begin
            @(negedge clk);
            if (k == A + 5) req = 1'b0;
            if (ack === 1'b1) begin
                acks++;
                if (first_ack < 0) first_ack = k;
                last_ack = k;
                if (k == A) check("b2b busy in ack cycle", busy, 1'b0);
            end
            if (cs0 && !prev_cs && cs_rise < 0) cs_rise = k;
            if (!cs0 && prev_cs && k > 1 && cs_fall2 < 0) cs_fall2 = k;
            prev_cs = cs0;
        end
        check("b2b ack count", acks, 2);
        check("b2b first ack", first_ack, A);
        check("b2b second ack", last_ack, 2 * A);
        check("b2b second cs fall", cs_fall2, A + 1);
        check("b2b cs high cycles", cs_fall2 - cs_rise, G + 1);
        check("b2b rdata untouched", rdata, rd_hold);

        // HALF=3, CS_GAP=4 read with miso tied high.
        @(negedge clk);
        req3 = 1'b1; addr3 = 24'($urandom);
        sclk_err = 0; cs_err = 0; rises = 0; ack_at = -1; acks = 0; prev_sclk = 1'b0;
        for (int k = 1; k <= A3 + 1; k++) begin
            @(negedge clk);
            req3 = 1'b0;
            if (sclk3 !== exp_sclk(k, H3)) sclk_err++;
            if (cs3 !== !(k >= 1 && k <= 129 * H3)) cs_err++;
            if (sclk3 && !prev_sclk) rises++;
            if (ack3 === 1'b1) begin
                acks++;
                ack_at = k;
            end
            prev_sclk = sclk3;
        end
        check("h3 sclk pattern errs", sclk_err, 0);
        check("h3 cs0 pattern errs", cs_err, 0);
        check("h3 rising edges", rises, 64);
        check("h3 ack count", acks, 1);
        check("h3 ack cycle", ack_at, A3);
        check("h3 rdata", rdata3, 32'hFFFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
